// File: rtl/trap_ctrl.sv
// Trap sequencer in front of the CSR file: arbitrates exceptions, mret and interrupts,
// drains the pipe, pulses the CSR commit, then hands the redirect PC to fetch.
module trap_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        ctrl_clk,
  input  logic        ctrl_reset_n,
  input  logic [2:0]  irq_raw,
  output logic [2:0]  ctrl_mxip,
  input  logic        ctrl_mie,
  input  logic [2:0]  ctrl_mxie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic        mret_valid,
  output logic        exc_ready,
  input  logic [31:0] next_pc,
  input  logic        pipe_idle,
  output logic        stall,
  output logic        ctrl_trap,
  output logic        ctrl_mret,
  output logic [31:0] trap_pc,
  output logic [4:0]  trap_info,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  logic [2:0]  sync_r [SYNC_STAGES];
  logic [2:0]  pend_s;
  logic        int_req_s;
  logic [3:0]  irq_code_s;
  logic [31:0] base_s;
  logic [31:0] redir_nxt_s;

  state_t      state_r;
  logic        mret_r;
  logic [4:0]  info_r;
  logic [31:0] epc_r;

  // Pending-interrupt synchroniser chain
  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 3'b000;
    end else begin
      sync_r[0] <= irq_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  assign ctrl_mxip = sync_r[SYNC_STAGES-1];
  assign pend_s    = ctrl_mxie & ctrl_mxip;
  assign int_req_s = ctrl_mie & (|pend_s);
  assign base_s    = {mtvec[31:2], 2'b00};

  // Reset gating keeps every output low while reset is held, even this combinational one
  assign exc_ready = ctrl_reset_n & (state_r == IDLE) & (exc_valid | mret_valid);

  // Interrupt code selection: external > software > timer
  always_comb begin
    irq_code_s = 4'd7;
    if (pend_s[0]) begin
      irq_code_s = 4'd11;
    end else if (pend_s[1]) begin
      irq_code_s = 4'd3;
    end else begin
      irq_code_s = 4'd7;
    end
  end

  // Redirect target, sampled during COMMIT before the CSR file updates
  always_comb begin
    redir_nxt_s = base_s;
    if (mret_r) begin
      redir_nxt_s = mepc;
    end else if (VECTORED_EN && info_r[4] && (mtvec[1:0] == 2'b01)) begin
      redir_nxt_s = base_s + {26'd0, info_r[3:0], 2'b00};
    end else begin
      redir_nxt_s = base_s;
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_r     <= IDLE;
      mret_r      <= 1'b0;
      info_r      <= 5'd0;
      epc_r       <= 32'd0;
      stall       <= 1'b0;
      ctrl_trap   <= 1'b0;
      ctrl_mret   <= 1'b0;
      trap_pc     <= 32'd0;
      trap_info   <= 5'd0;
      redir_valid <= 1'b0;
      redir_pc    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (exc_valid) begin
            info_r  <= {1'b0, exc_cause};
            epc_r   <= exc_pc;
            mret_r  <= 1'b0;
            stall   <= 1'b1;
            state_r <= DRAIN;
          end else if (mret_valid) begin
            mret_r  <= 1'b1;
            stall   <= 1'b1;
            state_r <= DRAIN;
          end else if (int_req_s) begin
            info_r  <= {1'b1, irq_code_s};
            epc_r   <= next_pc;
            mret_r  <= 1'b0;
            stall   <= 1'b1;
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_idle) begin
            ctrl_trap <= 1'b1;
            ctrl_mret <= mret_r;
            trap_pc   <= epc_r;
            trap_info <= info_r;
            state_r   <= COMMIT;
          end
        end
        COMMIT: begin
          ctrl_trap   <= 1'b0;
          ctrl_mret   <= 1'b0;
          trap_pc     <= 32'd0;
          trap_info   <= 5'd0;
          redir_valid <= 1'b1;
          redir_pc    <= redir_nxt_s;
          state_r     <= REDIRECT;
        end
        REDIRECT: begin
          if (redir_ready) begin
            redir_valid <= 1'b0;
            redir_pc    <= 32'd0;
            stall       <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          stall       <= 1'b0;
          ctrl_trap   <= 1'b0;
          ctrl_mret   <= 1'b0;
          trap_pc     <= 32'd0;
          trap_info   <= 5'd0;
          redir_valid <= 1'b0;
          redir_pc    <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

  logic        ctrl_clk = 1'b0;
  logic        ctrl_reset_n;
  logic [2:0]  irq_raw;
  logic [2:0]  ctrl_mxip;
  logic        ctrl_mie;
  logic [2:0]  ctrl_mxie;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic        exc_ready;
  logic [31:0] next_pc;
  logic        pipe_idle;
  logic        stall;
  logic        ctrl_trap;
  logic        ctrl_mret;
  logic [31:0] trap_pc;
  logic [4:0]  trap_info;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  int n_checks = 0;
  int n_pass   = 0;

  trap_ctrl #(.SYNC_STAGES(2), .VECTORED_EN(1'b1)) dut (
    .ctrl_clk(ctrl_clk), .ctrl_reset_n(ctrl_reset_n), .irq_raw(irq_raw),
    .ctrl_mxip(ctrl_mxip), .ctrl_mie(ctrl_mie), .ctrl_mxie(ctrl_mxie),
    .mtvec(mtvec), .mepc(mepc), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .mret_valid(mret_valid), .exc_ready(exc_ready),
    .next_pc(next_pc), .pipe_idle(pipe_idle), .stall(stall),
    .ctrl_trap(ctrl_trap), .ctrl_mret(ctrl_mret), .trap_pc(trap_pc),
    .trap_info(trap_info), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    irq_raw = 3'b000; ctrl_mie = 1'b0; ctrl_mxie = 3'b000;
    mtvec = 32'd0; mepc = 32'd0; exc_valid = 1'b0; exc_cause = 4'd0;
    exc_pc = 32'd0; mret_valid = 1'b0; next_pc = 32'd0; pipe_idle = 1'b1;
    redir_ready = 1'b0;
    tick(); tick();
    check("rst_stall", stall, 1'b0);
    check("rst_trap", ctrl_trap, 1'b0);
    check("rst_redir_valid", redir_valid, 1'b0);
    check("rst_mxip", ctrl_mxip, 3'b000);
    ctrl_reset_n = 1'b1;
    tick();

    // Exception, mtvec mode 1 is ignored for exceptions
    mtvec = 32'h801; exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100;
    #1 check("exc_ready", exc_ready, 1'b1);
    check("exc_stall_idle", stall, 1'b0);
    tick(); exc_valid = 1'b0;
    check("exc_drain_stall", stall, 1'b1);
    check("exc_drain_trap", ctrl_trap, 1'b0);
    tick();
    check("exc_commit_trap", ctrl_trap, 1'b1);
    check("exc_commit_mret", ctrl_mret, 1'b0);
    check("exc_trap_info", trap_info, 5'h02);
    check("exc_trap_pc", trap_pc, 32'h100);
    tick();
    check("exc_trap_pulse_end", ctrl_trap, 1'b0);
    check("exc_trap_pc_clear", trap_pc, 32'h0);
    check("exc_redir_valid", redir_valid, 1'b1);
    check("exc_redir_pc", redir_pc, 32'h800);
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;
    check("exc_back_idle_stall", stall, 1'b0);
    check("exc_back_idle_valid", redir_valid, 1'b0);

    // Vectored timer interrupt through the synchroniser
    ctrl_mie = 1'b1; ctrl_mxie = 3'b100; next_pc = 32'h200; mtvec = 32'h1001;
    irq_raw = 3'b100;
    tick();
    check("irq_sync_stage1", ctrl_mxip, 3'b000);
    tick();
    check("irq_sync_stage2", ctrl_mxip, 3'b100);
    check("irq_exc_ready_low", exc_ready, 1'b0);
    check("irq_idle_stall", stall, 1'b0);
    tick();
    check("irq_drain_stall", stall, 1'b1);
    irq_raw = 3'b000; ctrl_mie = 1'b0;
    tick();
    check("irq_commit_trap", ctrl_trap, 1'b1);
    check("irq_trap_info", trap_info, 5'h17);
    check("irq_trap_pc", trap_pc, 32'h200);
    tick();
    check("irq_redir_pc", redir_pc, 32'h101C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hs_redir_valid_held", redir_valid, 1'b1);
      check("hs_redir_pc_stable", redir_pc, 32'h101C);
      check("hs_stall_held", stall, 1'b1);
    end
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;
    check("hs_idle_stall", stall, 1'b0);
    check("hs_idle_valid", redir_valid, 1'b0);

    // Priority: exception wins over three pending interrupts, then external follows
    ctrl_mie = 1'b1; ctrl_mxie = 3'b111; irq_raw = 3'b111; next_pc = 32'h400;
    tick();
    tick();
    exc_valid = 1'b1; exc_cause = 4'd5; exc_pc = 32'h300;
    #1 check("pri_exc_ready", exc_ready, 1'b1);
    tick(); exc_valid = 1'b0;
    tick();
    check("pri_first_info", trap_info, 5'h05);
    check("pri_first_pc", trap_pc, 32'h300);
    tick();
    check("pri_first_redir", redir_pc, 32'h1000);
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;
    check("pri_reentry_exc_ready", exc_ready, 1'b0);
    check("pri_reentry_stall", stall, 1'b0);
    tick();
    check("pri_second_drain", stall, 1'b1);
    ctrl_mie = 1'b0; irq_raw = 3'b000;
    tick();
    check("pri_second_info", trap_info, 5'h1B);
    check("pri_second_pc", trap_pc, 32'h400);
    tick();
    check("pri_second_redir", redir_pc, 32'h102C);
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;

    // mret
    mret_valid = 1'b1; mepc = 32'h344;
    #1 check("mret_exc_ready", exc_ready, 1'b1);
    tick(); mret_valid = 1'b0;
    tick();
    check("mret_trap", ctrl_trap, 1'b1);
    check("mret_flag", ctrl_mret, 1'b1);
    tick();
    check("mret_trap_end", ctrl_trap, 1'b0);
    check("mret_flag_end", ctrl_mret, 1'b0);
    check("mret_redir_pc", redir_pc, 32'h344);
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;

    // Long drain, mode 0 base
    pipe_idle = 1'b0; mtvec = 32'h2000; exc_valid = 1'b1; exc_cause = 4'd1; exc_pc = 32'h500;
    tick(); exc_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("drain_stall", stall, 1'b1);
      check("drain_no_trap", ctrl_trap, 1'b0);
      tick();
    end
    pipe_idle = 1'b1;
    check("drain_still_waiting", ctrl_trap, 1'b0);
    tick();
    check("drain_commit_trap", ctrl_trap, 1'b1);
    check("drain_commit_info", trap_info, 5'h01);
    tick();
    check("drain_redir_pc", redir_pc, 32'h2000);
    redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;

    // Reset mid-DRAIN
    pipe_idle = 1'b0; exc_valid = 1'b1; exc_cause = 4'd3; exc_pc = 32'h600;
    tick();
    check("rstmid_drain_stall", stall, 1'b1);
    #2 ctrl_reset_n = 1'b0;
    #1;
    check("rstmid_stall", stall, 1'b0);
    check("rstmid_trap", ctrl_trap, 1'b0);
    check("rstmid_redir_valid", redir_valid, 1'b0);
    check("rstmid_exc_ready", exc_ready, 1'b0);
    exc_valid = 1'b0; pipe_idle = 1'b1;
    tick();
    ctrl_reset_n = 1'b1;
    tick();
    check("rstmid_idle_stall", stall, 1'b0);
    tick();
    check("rstmid_idle_trap", ctrl_trap, 1'b0);
    check("rstmid_idle_stall2", stall, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer directly upstream of the CSR file. Arbitrates synchronous exceptions, `mret` requests and pending interrupts.
- Drains the pipeline, then issues the one-cycle `ctrl_trap`/`ctrl_mret` commit pulse with `trap_pc`/`trap_info` that the CSR file consumes.
- Finally hands a redirect PC to fetch over a valid/ready handshake.
- Interrupt pending lines from the interrupt sources are synchronised here before use.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each `irq_raw` bit (legal 1..3).
- VECTORED_EN, 1, when 1, honour `mtvec` mode 1 for interrupts; when 0, always use direct mode.

Ports:
- ctrl_clk  in  1  clock.
- ctrl_reset_n  in  1  asynchronous, active-low reset.
- irq_raw  in  3  raw pending: [0] external, [1] software, [2] timer.
- ctrl_mxip  out  3  synchronised `irq_raw`; feeds the CSR file's `mip` view.
- ctrl_mie  in  1  `mstatus.MIE` from the CSR file.
- ctrl_mxie  in  3  per-source enables from the CSR file, same bit order as `irq_raw`.
- mtvec  in  32  current `mtvec` value from the CSR file.
- mepc  in  32  current `mepc` value from the CSR file.
- exc_valid  in  1  pipeline reports a synchronous exception.
- exc_cause  in  4  exception code.
- exc_pc  in  32  PC of the faulting instruction.
- mret_valid  in  1  pipeline reports a committed `mret`.
- exc_ready  out  1  request accepted this cycle; covers `exc_valid` and `mret_valid`.
- next_pc  in  32  PC of the next instruction to retire; used as `mepc` for interrupts.
- pipe_idle  in  1  no instruction in flight past fetch.
- stall  out  1  hold fetch/issue.
- ctrl_trap  out  1  commit pulse to the CSR file.
- ctrl_mret  out  1  qualifies `ctrl_trap` as an `mret`.
- trap_pc  out  32  PC to write into `mepc`.
- trap_info  out  5  {interrupt, code[3:0]}.
- redir_valid  out  1  redirect PC valid.
- redir_pc  out  32  redirect target.
- redir_ready  in  1  fetch accepts the redirect.

Behaviour:
- Reset (async assert, sync release): state IDLE, synchroniser flops 0, all outputs 0.
- `ctrl_mxip` is the last synchroniser stage. Latency from `irq_raw` to `ctrl_mxip` is SYNC_STAGES cycles.
- `int_req = ctrl_mie & |(ctrl_mxie & ctrl_mxip)`.
- Interrupt priority: external (code 11) > software (code 3) > timer (code 7).
- States: IDLE, DRAIN, COMMIT, REDIRECT.
- IDLE:
  - `exc_ready = exc_valid | mret_valid`.
  - Selection priority on acceptance: `exc_valid` > `mret_valid` > `int_req`.
  - Exception latches `{0, exc_cause}` and `exc_pc`.
  - `mret` latches the mret flag only.
  - Interrupt latches `{1, code}` and `next_pc`; `exc_ready` stays 0 for it.
  - On acceptance, go to DRAIN.
- DRAIN:
  - `stall = 1`; stay until `pipe_idle = 1`, then go to COMMIT.
  - Latched cause is final: interrupt deassertion or new requests during DRAIN are ignored, and `exc_ready` stays 0.
- COMMIT (exactly one cycle):
  - `ctrl_trap = 1`, `ctrl_mret = mret flag`, `stall = 1`.
  - `trap_pc`/`trap_info` show the latched values; they are 0 in all other states.
  - Compute `redir_pc` from pre-commit CSR values, then go to REDIRECT:
    - `mret`: `mepc`.
    - Exception, or mode 0: `{mtvec[31:2], 2'b00}`.
    - Interrupt with VECTORED_EN=1 and `mtvec[1:0]=1`: `{mtvec[31:2], 2'b00} + 4*code`, computed modulo 2^32.
- REDIRECT:
  - `redir_valid = 1` and `stall = 1`; `redir_pc` is held stable.
  - When `redir_valid & redir_ready`, go to IDLE; `stall` drops the next cycle.
- Back-to-back: a request present on the cycle IDLE is re-entered is accepted that same cycle.
- Reset asserted in any state immediately forces IDLE and zero outputs; no partial `ctrl_trap` is ever emitted.

Test Plan:
- Reset: `ctrl_reset_n = 0` mid-DRAIN -> all outputs 0 the same cycle; after release, IDLE with `stall = 0`.
- Exception: `exc_valid = 1`, `exc_cause = 2`, `exc_pc = 0x100`, `mtvec = 0x801`, `pipe_idle = 1` -> `exc_ready` that cycle; COMMIT pulse with `trap_info = 0x02`, `trap_pc = 0x100`; `redir_pc = 0x800`.
- Vectored interrupt: `ctrl_mie = 1`, `ctrl_mxie = 3'b100`, `irq_raw[2]` rises, `next_pc = 0x200`, `mtvec = 0x1001` -> `ctrl_mxip[2]` high 2 cycles later; `trap_info = 0x17`, `trap_pc = 0x200`; `redir_pc = 0x101C`.
- Priority: external, software and timer all pending and enabled, with `exc_valid` in the same cycle -> exception taken first; next entry takes code 11.
- mret: `mret_valid = 1`, `mepc = 0x344` -> `ctrl_trap` and `ctrl_mret` high for one cycle together; `redir_pc = 0x344`.
- Handshake and drain: hold `pipe_idle = 0` for 5 cycles -> `stall = 1` with no `ctrl_trap` throughout; hold `redir_ready = 0` for 3 cycles -> `redir_pc` stable and `redir_valid` held; IDLE one cycle after ready.
